// File: rtl/spi_pkg.sv
// Shared types and constants for the hydrophone SPI frame slave.
//   state_t       : frame FSM states
//   HDR_W         : status header width sent ahead of the samples
//   HDR_*_BIT/W   : header field positions (fresh, abort, sequence)
package spi_pkg;
  localparam int HDR_W         = 8;
  localparam int HDR_FRESH_BIT = 7;
  localparam int HDR_ABORT_BIT = 6;
  localparam int HDR_SEQ_W     = 6;

  typedef enum logic [1:0] {IDLE, SHIFT, TAIL} state_t;
endpackage

// File: rtl/spi_slave_frame_tx_if.sv
// Sample handshake and SPI pin bundle for spi_slave_frame_tx.
//   in_data/in_valid/in_ready : sample set handshake, ch0 in the MSBs
//   sclk/cs/mosi              : raw asynchronous SPI pins from the master
//   miso/miso_oe              : serial data and its output enable
//   frame_done/frame_abort    : 1-cycle frame status pulses
//   rx_cmd/rx_valid           : captured command byte and its update pulse
// modport slave is the SPI slave (DUT) side, master the producer/SPI master side.
interface spi_slave_frame_tx_if
  import spi_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int WORD_W = 16
);
  logic [NUM_CH*WORD_W-1:0] in_data;
  logic                     in_valid, in_ready;
  logic                     sclk, cs, mosi;
  logic                     miso, miso_oe;
  logic                     frame_done, frame_abort;
  logic [HDR_W-1:0]         rx_cmd;
  logic                     rx_valid;

  modport slave (
    input  in_data, in_valid, sclk, cs, mosi,
    output in_ready, miso, miso_oe, frame_done, frame_abort, rx_cmd, rx_valid
  );
  modport master (
    output in_data, in_valid, sclk, cs, mosi,
    input  in_ready, miso, miso_oe, frame_done, frame_abort, rx_cmd, rx_valid
  );
endinterface

// File: rtl/spi_pin_sync.sv
// Synchroniser plus edge detector for one asynchronous SPI pin.
//   clk, rst : system clock, async active-low reset
//   d        : raw pin
//   level    : synchronised level
//   rise/fall: 1-cycle pulses on synchronised edges
// Everything resets to 0, so a cs already low when reset releases produces
// no falling edge; the FSM waits for a genuine new one.
module spi_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;
endmodule

// File: rtl/spi_slave_frame_tx.sv
// Oversampling SPI slave: shifts {status header, NUM_CH x WORD_W samples}
// out on miso MSB first and captures the first 8 mosi bits as a command.
//   clk, rst : system clock (>= 8x sclk), async active-low reset
//   bus      : sample handshake + SPI pins + frame status (slave modport)
// Header = {fresh, prev-frame-aborted, seq[5:0]}. All four SPI modes via CPOL/CPHA.
module spi_slave_frame_tx
  import spi_pkg::*;
#(
  parameter int WORD_W      = 16,
  parameter int NUM_CH      = 4,
  parameter bit CPOL        = 1'b0,
  parameter bit CPHA        = 1'b0,
  parameter int SYNC_STAGES = 2
) (
  input logic                 clk,
  input logic                 rst,
  spi_slave_frame_tx_if.slave bus
);
  localparam int DATA_W     = NUM_CH * WORD_W;
  localparam int FRAME_BITS = HDR_W + DATA_W;
  localparam int CNT_W      = $clog2(FRAME_BITS);

  // pin index 0 = sclk, 1 = cs, 2 = mosi
  logic [2:0] pin_d, pin_lvl, pin_rise, pin_fall;
  assign pin_d = {bus.mosi, bus.cs, bus.sclk};

  for (genvar p = 0; p < 3; p++) begin : g_sync
    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk(clk), .rst(rst), .d(pin_d[p]),
      .level(pin_lvl[p]), .rise(pin_rise[p]), .fall(pin_fall[p])
    );
  end

  logic unused_pins;
  assign unused_pins = ^{pin_lvl[1:0], pin_rise[2], pin_fall[2]};

  logic lead_e, trail_e, cap_e, lch_e, cs_fall, cs_rise, mosi_s;
  assign lead_e  = CPOL ? pin_fall[0] : pin_rise[0];
  assign trail_e = CPOL ? pin_rise[0] : pin_fall[0];
  assign cap_e   = CPHA ? trail_e : lead_e;
  assign lch_e   = CPHA ? lead_e  : trail_e;
  assign cs_fall = pin_fall[1];
  assign cs_rise = pin_rise[1];
  assign mosi_s  = pin_lvl[2];

  state_t                state_q, state_d;
  logic [DATA_W-1:0]     hold_q;
  logic                  hold_full_q, abort_q, primed_q;
  logic [HDR_SEQ_W-1:0]  seq_q;
  logic [FRAME_BITS-1:0] sh_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [7:0]            rx_sh_q;
  logic [3:0]            rx_cnt_q;
  logic                  miso_q, oe_q, done_q, abort_p_q;
  logic [HDR_W-1:0]      rx_cmd_q;
  logic [1:0]            vld_pipe;
  logic [HDR_W-1:0]      hdr;
  logic                  acc, rx_byte;
  logic                  do_load, do_cap, do_lch, do_done, do_abort, do_end;

  assign acc     = bus.in_valid & ~hold_full_q;
  assign rx_byte = do_cap && (rx_cnt_q == 4'd7);

  always_comb begin
    hdr                = '0;
    hdr[HDR_FRESH_BIT] = hold_full_q;
    hdr[HDR_ABORT_BIT] = abort_q;
    hdr[HDR_SEQ_W-1:0] = seq_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // primed_q blocks the edge that would otherwise come "before" the first
  // bit: the CPHA=0 trailing edge before any capture, or the CPHA=1 capture
  // before the first launch.
  always_comb begin
    state_d  = state_q;
    do_load  = 1'b0;
    do_cap   = 1'b0;
    do_lch   = 1'b0;
    do_done  = 1'b0;
    do_abort = 1'b0;
    do_end   = 1'b0;
    unique case (state_q)
      IDLE: if (cs_fall) begin
        do_load = 1'b1;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (cs_rise) begin
          do_abort = 1'b1;
          do_end   = 1'b1;
          state_d  = IDLE;
        end else begin
          if (cap_e && (primed_q || !CPHA)) begin
            do_cap = 1'b1;
            if (cnt_q == '0) begin
              do_done = 1'b1;
              state_d = TAIL;
            end
          end
          if (lch_e && (primed_q || CPHA)) do_lch = 1'b1;
        end
      end
      TAIL: if (cs_rise) begin
        do_end  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      seq_q       <= '0;
      abort_q     <= 1'b0;
      primed_q    <= 1'b0;
      sh_q        <= '0;
      cnt_q       <= '0;
      rx_sh_q     <= '0;
      rx_cnt_q    <= '0;
      miso_q      <= 1'b0;
      oe_q        <= 1'b0;
      done_q      <= 1'b0;
      abort_p_q   <= 1'b0;
      rx_cmd_q    <= '0;
      vld_pipe    <= '0;
    end else begin
      done_q    <= do_done;
      abort_p_q <= do_abort;
      vld_pipe  <= {vld_pipe[0], rx_byte};
      if (do_load) begin
        sh_q        <= {hdr, hold_q};
        cnt_q       <= CNT_W'(FRAME_BITS - 1);
        primed_q    <= 1'b0;
        rx_cnt_q    <= '0;
        hold_full_q <= 1'b0;
        abort_q     <= 1'b0;
        oe_q        <= 1'b1;
        miso_q      <= CPHA ? 1'b0 : hdr[HDR_W-1];
      end
      // Placed after the load so a same-cycle accept leaves hold_full set;
      // the frame already took the old hold and old fresh bit.
      if (acc) begin
        hold_q      <= bus.in_data;
        hold_full_q <= 1'b1;
        seq_q       <= seq_q + HDR_SEQ_W'(1);
      end
      if (do_cap) begin
        primed_q <= 1'b1;
        if (rx_cnt_q != 4'd8) begin
          rx_sh_q  <= {rx_sh_q[6:0], mosi_s};
          rx_cnt_q <= rx_cnt_q + 4'd1;
        end
        if (rx_byte) rx_cmd_q <= {rx_sh_q[6:0], mosi_s};
      end
      if (do_lch) begin
        primed_q <= 1'b1;
        if (CPHA && !primed_q) begin
          miso_q <= sh_q[FRAME_BITS-1];
        end else begin
          sh_q   <= sh_q << 1;
          miso_q <= sh_q[FRAME_BITS-2];
          cnt_q  <= cnt_q - CNT_W'(1);
        end
      end
      if (do_done) miso_q <= 1'b0;
      if (do_abort) abort_q <= 1'b1;
      if (do_end) begin
        miso_q <= 1'b0;
        oe_q   <= 1'b0;
      end
    end
  end

  assign bus.in_ready    = ~hold_full_q;
  assign bus.miso        = miso_q;
  assign bus.miso_oe     = oe_q;
  assign bus.frame_done  = done_q;
  assign bus.frame_abort = abort_p_q;
  assign bus.rx_cmd      = rx_cmd_q;
  assign bus.rx_valid    = vld_pipe[1];
endmodule

// File: tb/tb_spi_slave_frame_tx.sv
// Bench: four DUTs (SPI modes 0..3) share one master stimulus; each mode's
// master samples miso at its own capture point. Table rows cover frame
// content, stale data, abort flag, partial byte and same-cycle accept.
module tb_spi_slave_frame_tx;
  localparam int NUM_CH = 4, WORD_W = 16, DATA_W = 64, FRAME_BITS = 72;
  localparam int HALF = 8, SYNC = 2;
  localparam logic [DATA_W-1:0] D1 = 64'h1234_5678_9ABC_DEF0;
  localparam logic [DATA_W-1:0] D2 = 64'hCAFE_0123_4567_89AB;
  localparam logic [DATA_W-1:0] D3 = 64'h0F0F_F0F0_A5A5_5A5A;

  logic gclk = 1'b0, grst_n = 1'b0;
  always #5 gclk = ~gclk;

  logic              sck_ph = 1'b0, cs_n = 1'b1, mosi = 1'b0, in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;

  spi_slave_frame_tx_if #(.NUM_CH(NUM_CH), .WORD_W(WORD_W)) bus0(), bus1(), bus2(), bus3();

  assign bus0.sclk = sck_ph;  assign bus1.sclk = sck_ph;
  assign bus2.sclk = ~sck_ph; assign bus3.sclk = ~sck_ph;
  assign bus0.cs = cs_n;      assign bus1.cs = cs_n;      assign bus2.cs = cs_n;      assign bus3.cs = cs_n;
  assign bus0.mosi = mosi;    assign bus1.mosi = mosi;    assign bus2.mosi = mosi;    assign bus3.mosi = mosi;
  assign bus0.in_data = in_data;   assign bus1.in_data = in_data;
  assign bus2.in_data = in_data;   assign bus3.in_data = in_data;
  assign bus0.in_valid = in_valid; assign bus1.in_valid = in_valid;
  assign bus2.in_valid = in_valid; assign bus3.in_valid = in_valid;

  spi_slave_frame_tx #(.WORD_W(WORD_W), .NUM_CH(NUM_CH), .CPOL(1'b0), .CPHA(1'b0), .SYNC_STAGES(SYNC))
    dut0 (.clk(gclk), .rst(grst_n), .bus(bus0));
  spi_slave_frame_tx #(.WORD_W(WORD_W), .NUM_CH(NUM_CH), .CPOL(1'b0), .CPHA(1'b1), .SYNC_STAGES(SYNC))
    dut1 (.clk(gclk), .rst(grst_n), .bus(bus1));
  spi_slave_frame_tx #(.WORD_W(WORD_W), .NUM_CH(NUM_CH), .CPOL(1'b1), .CPHA(1'b0), .SYNC_STAGES(SYNC))
    dut2 (.clk(gclk), .rst(grst_n), .bus(bus2));
  spi_slave_frame_tx #(.WORD_W(WORD_W), .NUM_CH(NUM_CH), .CPOL(1'b1), .CPHA(1'b1), .SYNC_STAGES(SYNC))
    dut3 (.clk(gclk), .rst(grst_n), .bus(bus3));

  logic [3:0]      miso_v, oe_v, done_v, abort_v, rdy_v, rxv_v;
  logic [3:0][7:0] rxc_v;
  assign miso_v  = {bus3.miso, bus2.miso, bus1.miso, bus0.miso};
  assign oe_v    = {bus3.miso_oe, bus2.miso_oe, bus1.miso_oe, bus0.miso_oe};
  assign done_v  = {bus3.frame_done, bus2.frame_done, bus1.frame_done, bus0.frame_done};
  assign abort_v = {bus3.frame_abort, bus2.frame_abort, bus1.frame_abort, bus0.frame_abort};
  assign rdy_v   = {bus3.in_ready, bus2.in_ready, bus1.in_ready, bus0.in_ready};
  assign rxv_v   = {bus3.rx_valid, bus2.rx_valid, bus1.rx_valid, bus0.rx_valid};
  assign rxc_v   = {bus3.rx_cmd, bus2.rx_cmd, bus1.rx_cmd, bus0.rx_cmd};

  // pulse counters, sampled on the inactive clock edge
  int done_cnt[4], abort_cnt[4], rxv_cnt[4];
  always @(negedge gclk)
    for (int m = 0; m < 4; m++) begin
      if (done_v[m])  done_cnt[m]  <= done_cnt[m] + 1;
      if (abort_v[m]) abort_cnt[m] <= abort_cnt[m] + 1;
      if (rxv_v[m])   rxv_cnt[m]   <= rxv_cnt[m] + 1;
    end

  int n_chk = 0, n_err = 0;
  logic [FRAME_BITS-1:0] rd [4];
  int d0[4], a0[4], r0[4];

  typedef struct {
    bit                acc;
    bit                sim;
    logic [DATA_W-1:0] data;
    int                nbits;
    logic [7:0]        cmd;
    logic [7:0]        hdr;
    logic [DATA_W-1:0] exp_data;
    int                d_done, d_abort, d_rxv;
    logic [7:0]        rx;
    bit                rdy;
  } vec_t;
  vec_t vt[8];

  task automatic chk(input string nm, input logic [FRAME_BITS-1:0] act, input logic [FRAME_BITS-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge gclk);
  endtask

  task automatic snap();
    d0 = done_cnt; a0 = abort_cnt; r0 = rxv_cnt;
  endtask

  task automatic accept(input logic [DATA_W-1:0] d);
    in_data = d; in_valid = 1'b1;
    @(negedge gclk);
    in_valid = 1'b0;
    @(negedge gclk);
  endtask

  // One master transfer; caller is aligned to a falling gclk edge.
  task automatic xfer(input int nbits, input logic [7:0] cmd, input bit sim,
                      input logic [DATA_W-1:0] sdata, input bit raise);
    int nb;
    for (int m = 0; m < 4; m++) rd[m] = '0;
    mosi = cmd[7];
    cs_n = 1'b0;
    if (sim) begin
      // lands in_valid on the clock where the synchronised cs fall acts
      repeat (SYNC) @(posedge gclk);
      @(negedge gclk);
      in_data = sdata; in_valid = 1'b1;
      @(negedge gclk);
      in_valid = 1'b0;
      wait_clk(HALF - 3);
    end else wait_clk(HALF);
    for (int b = 0; b < nbits; b++) begin
      for (int m = 0; m < 4; m++) if (m % 2 == 0) rd[m] = {rd[m][FRAME_BITS-2:0], miso_v[m]};
      sck_ph = 1'b1;
      wait_clk(HALF);
      for (int m = 0; m < 4; m++) if (m % 2 == 1) rd[m] = {rd[m][FRAME_BITS-2:0], miso_v[m]};
      sck_ph = 1'b0;
      wait_clk(HALF / 2);
      nb = b + 1;
      mosi = (nb < 8) ? cmd[3'(7 - nb)] : 1'b0;
      wait_clk(HALF / 2);
    end
    if (raise) begin
      cs_n = 1'b1;
      wait_clk(HALF);
    end
  endtask

  initial begin
    logic [FRAME_BITS-1:0] exp;
    //           acc sim data nbits cmd    hdr    exp_data done abort rxv rx    rdy
    vt[0] = '{1'b1, 1'b0, D1, 72, 8'hA5, 8'h81, D1, 1, 0, 1, 8'hA5, 1'b1};
    vt[1] = '{1'b0, 1'b0, D1, 72, 8'h3C, 8'h01, D1, 1, 0, 1, 8'h3C, 1'b1};
    vt[2] = '{1'b0, 1'b0, D1, 20, 8'h5A, 8'h01, D1, 0, 1, 1, 8'h5A, 1'b1};
    vt[3] = '{1'b0, 1'b0, D1, 72, 8'hC3, 8'h41, D1, 1, 0, 1, 8'hC3, 1'b1};
    vt[4] = '{1'b0, 1'b0, D1, 5,  8'hFF, 8'h01, D1, 0, 1, 0, 8'hC3, 1'b1};
    vt[5] = '{1'b0, 1'b0, D1, 72, 8'h0F, 8'h41, D1, 1, 0, 1, 8'h0F, 1'b1};
    vt[6] = '{1'b1, 1'b1, D2, 72, 8'h96, 8'h01, D1, 1, 0, 1, 8'h96, 1'b0};
    vt[7] = '{1'b0, 1'b0, D2, 72, 8'h69, 8'h82, D2, 1, 0, 1, 8'h69, 1'b1};

    wait_clk(4);
    chk("reset in_ready", 72'(rdy_v), 72'(4'hF));
    chk("reset miso_oe", 72'(oe_v), 72'(0));
    chk("reset miso", 72'(miso_v), 72'(0));
    chk("reset pulses", 72'({done_v, abort_v, rxv_v}), 72'(0));
    chk("reset rx_cmd", 72'(rxc_v), 72'(0));
    grst_n = 1'b1;
    wait_clk(6);
    chk("post-reset miso_oe", 72'(oe_v), 72'(0));

    for (int i = 0; i < 8; i++) begin
      if (vt[i].acc && !vt[i].sim) begin
        accept(vt[i].data);
        chk($sformatf("r%0d accept in_ready", i), 72'(rdy_v), 72'(0));
      end
      snap();
      xfer(vt[i].nbits, vt[i].cmd, vt[i].sim, vt[i].data, 1'b1);
      exp = {vt[i].hdr, vt[i].exp_data} >> (FRAME_BITS - vt[i].nbits);
      for (int m = 0; m < 4; m++) begin
        chk($sformatf("r%0d m%0d frame", i, m), rd[m], exp);
        chk($sformatf("r%0d m%0d frame_done", i, m), 72'(done_cnt[m] - d0[m]), 72'(vt[i].d_done));
        chk($sformatf("r%0d m%0d frame_abort", i, m), 72'(abort_cnt[m] - a0[m]), 72'(vt[i].d_abort));
        chk($sformatf("r%0d m%0d rx_valid", i, m), 72'(rxv_cnt[m] - r0[m]), 72'(vt[i].d_rxv));
        chk($sformatf("r%0d m%0d rx_cmd", i, m), 72'(rxc_v[m]), 72'(vt[i].rx));
      end
      chk($sformatf("r%0d in_ready", i), 72'(rdy_v), vt[i].rdy ? 72'(4'hF) : 72'(0));
      chk($sformatf("r%0d miso_oe off", i), 72'(oe_v), 72'(0));
    end

    // reset in the middle of a frame, cs held low through release
    snap();
    xfer(20, 8'h11, 1'b0, '0, 1'b0);
    chk("mid-frame miso_oe", 72'(oe_v), 72'(4'hF));
    #3 grst_n = 1'b0;
    #1;
    chk("async reset miso_oe", 72'(oe_v), 72'(0));
    chk("async reset miso", 72'(miso_v), 72'(0));
    chk("async reset in_ready", 72'(rdy_v), 72'(4'hF));
    chk("async reset rx_cmd", 72'(rxc_v), 72'(0));
    wait_clk(3);
    grst_n = 1'b1;
    wait_clk(20);
    chk("cs low at release stays idle", 72'(oe_v), 72'(0));
    cs_n = 1'b1;
    wait_clk(HALF);
    for (int m = 0; m < 4; m++)
      chk($sformatf("idle cs rise no abort m%0d", m), 72'(abort_cnt[m] - a0[m]), 72'(0));

    // full frame then extra sclk edges while cs stays low
    accept(D3);
    snap();
    xfer(72, 8'h00, 1'b0, '0, 1'b0);
    for (int m = 0; m < 4; m++) begin
      chk($sformatf("tail m%0d frame", m), rd[m], {8'h81, D3});
      chk($sformatf("tail m%0d frame_done", m), 72'(done_cnt[m] - d0[m]), 72'(1));
    end
    for (int e = 0; e < 80; e++) begin
      sck_ph = ~sck_ph;
      wait_clk(HALF);
      chk($sformatf("tail edge%0d miso", e), 72'(miso_v), 72'(0));
      chk($sformatf("tail edge%0d miso_oe", e), 72'(oe_v), 72'(4'hF));
    end
    for (int m = 0; m < 4; m++)
      chk($sformatf("tail m%0d no second done", m), 72'(done_cnt[m] - d0[m]), 72'(1));
    cs_n = 1'b1;
    wait_clk(HALF);
    chk("tail cs rise miso_oe", 72'(oe_v), 72'(0));
    for (int m = 0; m < 4; m++)
      chk($sformatf("tail m%0d no abort", m), 72'(abort_cnt[m] - a0[m]), 72'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
